// File: rtl/axi_mem_pkg.sv
// axi_mem_pkg: state encodings, bus field positions and response codes for axi_mem_slave
package axi_mem_pkg;
   typedef enum logic {R_IDLE, R_DATA} rd_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
   localparam int AR_ADDR_MSB = 15;
   localparam int AR_ADDR_LSB = 8;
   localparam int AR_LEN_MSB  = 7;
   localparam int AR_LEN_LSB  = 4;
   localparam int AR_ID_MSB   = 3;
   localparam int AR_ID_LSB   = 0;
   localparam int AW_ADDR_MSB = 11;
   localparam int AW_ADDR_LSB = 4;
   localparam int AW_ID_MSB   = 3;
   localparam int AW_ID_LSB   = 0;
   localparam logic RESP_OK  = 1'b0;
   localparam logic RESP_ERR = 1'b1;
endpackage

// File: rtl/axi_mem_array.sv
// axi_mem_array: DEPTH x 8 byte store, synchronous write port, asynchronous read port
module axi_mem_array #(
   parameter int DEPTH = 256
) (
   input  logic       clk,
   input  logic       i_we,
   input  logic [7:0] i_waddr,
   input  logic [7:0] i_wdata,
   input  logic [7:0] i_raddr,
   output logic [7:0] o_rdata
);
   logic [7:0] r_mem [DEPTH];
   always_ff @(posedge clk)
      if (i_we) r_mem[i_waddr] <= i_wdata;
   assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/axi_mem_slave.sv
// axi_mem_slave: byte memory slave with independent read (AR/R) and write (AW/W/B) burst FSMs
module axi_mem_slave
   import axi_mem_pkg::*;
#(
   parameter int DEPTH      = 256,
   parameter int MAX_WBEATS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ARVALID,
   input  logic [15:0] ARBUS,
   output logic        ARREADY,
   output logic        RVALID,
   input  logic        RREADY,
   output logic [8:0]  RBUS,
   output logic        RLAST,
   input  logic        AWVALID,
   input  logic [11:0] AWBUS,
   output logic        AWREADY,
   input  logic        WVALID,
   input  logic [7:0]  WDATA,
   input  logic        WLAST,
   output logic        WREADY,
   output logic        BVALID,
   input  logic        BREADY,
   output logic [4:0]  BRESP
);
   localparam logic [7:0] W_LAST_OK = 8'(MAX_WBEATS - 1);
   rd_state_t r_rstate, w_rnext;
   wr_state_t r_wstate, w_wnext;
   logic [7:0] r_raddr, r_waddr, r_wbeat, w_rdata;
   logic [3:0] r_rlen, r_rbeat, r_wid;
   logic       r_werr, w_rlast, w_roor, w_woor, w_wfire;
   logic       w_unused_arid;

   // the R bus has no ID field, so ARID is never needed
   assign w_unused_arid = ^ARBUS[AR_ID_MSB:AR_ID_LSB];

   axi_mem_array #(.DEPTH(DEPTH)) u_array (
      .clk     (clk),
      .i_we    (w_wfire && !w_woor),
      .i_waddr (r_waddr),
      .i_wdata (WDATA),
      .i_raddr (r_raddr),
      .o_rdata (w_rdata)
   );

   always_comb begin
      ARREADY = r_rstate == R_IDLE;
      RVALID  = r_rstate == R_DATA;
      w_rlast = r_rbeat == r_rlen;
      w_roor  = 32'(r_raddr) >= DEPTH;
      RLAST   = RVALID && w_rlast;
      RBUS    = RVALID ? {w_roor ? 8'h00 : w_rdata, w_roor ? RESP_ERR : RESP_OK} : 9'd0;
      w_rnext = ARREADY ? (ARVALID ? R_DATA : R_IDLE) : ((RREADY && w_rlast) ? R_IDLE : R_DATA);
   end

   always_comb begin
      AWREADY = r_wstate == W_IDLE;
      WREADY  = r_wstate == W_DATA;
      BVALID  = r_wstate == W_RESP;
      BRESP   = BVALID ? {r_wid, r_werr} : 5'd0;
      w_wfire = WREADY && WVALID;
      w_woor  = 32'(r_waddr) >= DEPTH;
      w_wnext = AWREADY ? (AWVALID ? W_DATA : W_IDLE)
              : WREADY ? ((w_wfire && WLAST) ? W_RESP : W_DATA)
              : (BREADY ? W_IDLE : W_RESP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rstate <= R_IDLE;
         r_wstate <= W_IDLE;
      end else begin
         r_rstate <= w_rnext;
         r_wstate <= w_wnext;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_raddr <= '0;
         r_rlen  <= '0;
         r_rbeat <= '0;
         r_waddr <= '0;
         r_wid   <= '0;
         r_wbeat <= '0;
         r_werr  <= RESP_OK;
      end else begin
         if (ARREADY && ARVALID) begin
            r_raddr <= ARBUS[AR_ADDR_MSB:AR_ADDR_LSB];
            r_rlen  <= ARBUS[AR_LEN_MSB:AR_LEN_LSB];
            r_rbeat <= '0;
         end else if (RVALID && RREADY) begin
            r_raddr <= r_raddr + 8'd1;
            r_rbeat <= r_rbeat + 4'd1;
         end
         if (AWREADY && AWVALID) begin
            r_waddr <= AWBUS[AW_ADDR_MSB:AW_ADDR_LSB];
            r_wid   <= AWBUS[AW_ID_MSB:AW_ID_LSB];
            r_wbeat <= '0;
            r_werr  <= RESP_OK;
         end else if (w_wfire) begin
            r_waddr <= r_waddr + 8'd1;
            r_wbeat <= r_wbeat + 8'd1;
            // dropped out-of-range bytes and over-long bursts both make the response sticky-bad
            if (w_woor || (r_wbeat == W_LAST_OK && !WLAST)) r_werr <= RESP_ERR;
         end
      end
   end
endmodule

// File: tb/tb_axi_mem_slave.sv
// tb_axi_mem_slave: directed table-driven bench; instance a has DEPTH=256, instance b has DEPTH=192
module tb_axi_mem_slave;
   logic        clk, rst, arvalid, rready, awvalid, wvalid, wlast, bready;
   logic [15:0] arbus;
   logic [11:0] awbus;
   logic [7:0]  wdata;
   logic        a_arready, a_rvalid, a_rlast, a_awready, a_wready, a_bvalid;
   logic        b_arready, b_rvalid, b_rlast, b_awready, b_wready, b_bvalid;
   logic [8:0]  a_rbus, b_rbus;
   logic [4:0]  a_bresp, b_bresp;
   int          n_chk = 0;
   int          n_fail = 0;
   logic [7:0]  wbuf [32];
   logic [7:0]  exp_a [32];
   logic [7:0]  exp_b [32];
   logic        exp_rb [32];

   typedef struct {
      logic [7:0]       addr;
      logic [3:0]       id;
      int               n;
      logic [3:0][7:0]  d;
      logic             ea;
      logic             eb;
      logic [3:0][7:0]  db;
      logic [3:0]       rb;
      int               stall;
      logic [15:0]      rpat;
   } vec_t;
   vec_t vecs [4];

   axi_mem_slave #(.DEPTH(256), .MAX_WBEATS(16)) u_a (
      .clk(clk), .rst(rst), .ARVALID(arvalid), .ARBUS(arbus), .ARREADY(a_arready),
      .RVALID(a_rvalid), .RREADY(rready), .RBUS(a_rbus), .RLAST(a_rlast),
      .AWVALID(awvalid), .AWBUS(awbus), .AWREADY(a_awready), .WVALID(wvalid),
      .WDATA(wdata), .WLAST(wlast), .WREADY(a_wready), .BVALID(a_bvalid),
      .BREADY(bready), .BRESP(a_bresp));

   axi_mem_slave #(.DEPTH(192), .MAX_WBEATS(16)) u_b (
      .clk(clk), .rst(rst), .ARVALID(arvalid), .ARBUS(arbus), .ARREADY(b_arready),
      .RVALID(b_rvalid), .RREADY(rready), .RBUS(b_rbus), .RLAST(b_rlast),
      .AWVALID(awvalid), .AWBUS(awbus), .AWREADY(b_awready), .WVALID(wvalid),
      .WDATA(wdata), .WLAST(wlast), .WREADY(b_wready), .BVALID(b_bvalid),
      .BREADY(bready), .BRESP(b_bresp));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic sig(input int k);
      return k == 0 ? a_awready : k == 1 ? a_wready : k == 2 ? a_bvalid : a_arready;
   endfunction

   task automatic wait_for(input int k, input string nm);
      int t = 0;
      while (!sig(k) && t < 50) begin
         tick();
         t++;
      end
      chk({nm, "_seen"}, 32'(sig(k)), 1);
   endtask

   task automatic wr(input logic [7:0] addr, input logic [3:0] id, input int n,
                     input logic [4:0] ea, input logic [4:0] eb, input int stall);
      awvalid = 1'b1;
      awbus   = {addr, id};
      wait_for(0, "awready");
      tick();
      awvalid = 1'b0;
      for (int i = 0; i < n; i++) begin
         wvalid = 1'b1;
         wdata  = wbuf[i];
         wlast  = (i == n - 1);
         wait_for(1, "wready");
         tick();
      end
      wvalid = 1'b0;
      wlast  = 1'b0;
      wait_for(2, "bvalid");
      chk("bresp_a", a_bresp, ea);
      chk("bresp_b", b_bresp, eb);
      for (int s = 0; s < stall; s++) begin
         tick();
         chk("bvalid_hold", a_bvalid, 1);
         chk("bresp_hold", a_bresp, ea);
      end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      chk("bvalid_clear", a_bvalid, 0);
      chk("awready_back", a_awready, 1);
   endtask

   task automatic rd(input logic [7:0] addr, input logic [3:0] len, input logic [3:0] id,
                     input logic [15:0] pat);
      int beats = 0;
      int cyc = 0;
      arvalid = 1'b1;
      arbus   = {addr, len, id};
      wait_for(3, "arready");
      tick();
      arvalid = 1'b0;
      while (beats <= int'(len) && cyc < 100) begin
         rready = pat[cyc % 16];
         chk("rvalid", a_rvalid, 1);
         chk("arready_low", a_arready, 0);
         chk("rbus_a", a_rbus, {exp_a[beats], 1'b0});
         chk("rbus_b", b_rbus, {exp_b[beats], exp_rb[beats]});
         chk("rlast_a", a_rlast, beats == int'(len));
         chk("rlast_b", b_rlast, beats == int'(len));
         if (rready) beats++;
         tick();
         cyc++;
      end
      rready = 1'b0;
      chk("rbeats", beats, int'(len) + 1);
      chk("rvalid_done", a_rvalid, 0);
      chk("arready_done", a_arready, 1);
   endtask

   task automatic fill_exp(input logic [7:0] base, input int off, input int n);
      for (int i = 0; i < n; i++) begin
         logic [7:0] a;
         a = base + 8'(i);
         exp_a[i]  = wbuf[off + i];
         exp_b[i]  = (a >= 8'd192) ? 8'h00 : wbuf[off + i];
         exp_rb[i] = (a >= 8'd192);
      end
   endtask

   initial begin
      vecs[0] = '{8'h10, 4'd3, 3, {8'h00, 8'hC3, 8'hB2, 8'hA1}, 1'b0, 1'b0,
                  {8'h00, 8'hC3, 8'hB2, 8'hA1}, 4'b0000, 5, 16'hFFFF};
      vecs[1] = '{8'hFF, 4'd5, 2, {8'h00, 8'h00, 8'h22, 8'h11}, 1'b0, 1'b1,
                  {8'h00, 8'h00, 8'h22, 8'h00}, 4'b0001, 0, 16'hFFFF};
      vecs[2] = '{8'hBF, 4'd7, 2, {8'h00, 8'h00, 8'h6B, 8'h5A}, 1'b0, 1'b1,
                  {8'h00, 8'h00, 8'h00, 8'h5A}, 4'b0010, 0, 16'hFFFF};
      vecs[3] = '{8'h40, 4'hC, 4, {8'h7E, 8'hFF, 8'h80, 8'h01}, 1'b0, 1'b0,
                  {8'h7E, 8'hFF, 8'h80, 8'h01}, 4'b0000, 0, 16'h9999};
      rst = 1'b1;
      {arvalid, rready, awvalid, wvalid, wlast, bready} = '0;
      arbus = '0;
      awbus = '0;
      wdata = '0;
      tick();
      tick();
      chk("rst_arready", a_arready, 1);
      chk("rst_awready", a_awready, 1);
      chk("rst_rvalid", a_rvalid, 0);
      chk("rst_rlast", a_rlast, 0);
      chk("rst_wready", a_wready, 0);
      chk("rst_bvalid", a_bvalid, 0);
      chk("rst_rbus", a_rbus, 0);
      chk("rst_bresp", a_bresp, 0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      for (int v = 0; v < 4; v++) begin
         for (int i = 0; i < vecs[v].n; i++) begin
            wbuf[i]   = vecs[v].d[i];
            exp_a[i]  = vecs[v].d[i];
            exp_b[i]  = vecs[v].db[i];
            exp_rb[i] = vecs[v].rb[i];
         end
         wr(vecs[v].addr, vecs[v].id, vecs[v].n, {vecs[v].id, vecs[v].ea},
            {vecs[v].id, vecs[v].eb}, vecs[v].stall);
         rd(vecs[v].addr, 4'(vecs[v].n - 1), vecs[v].id, vecs[v].rpat);
      end

      for (int i = 0; i < 16; i++) wbuf[i] = 8'h60 + 8'(i);
      wr(8'h60, 4'd2, 16, {4'd2, 1'b0}, {4'd2, 1'b0}, 0);
      fill_exp(8'h60, 0, 16);
      rd(8'h60, 4'd15, 4'd2, 16'hFFFF);

      for (int i = 0; i < 17; i++) wbuf[i] = 8'(i * 3 + 1);
      wr(8'hF8, 4'd9, 17, {4'd9, 1'b1}, {4'd9, 1'b1}, 0);
      fill_exp(8'hF8, 0, 16);
      rd(8'hF8, 4'd15, 4'd9, 16'hFFFF);
      fill_exp(8'h08, 16, 1);
      rd(8'h08, 4'd0, 4'd9, 16'hFFFF);

      for (int i = 0; i < 4; i++) begin
         exp_a[i]  = vecs[3].d[i];
         exp_b[i]  = vecs[3].d[i];
         exp_rb[i] = 1'b0;
      end
      wbuf[0] = 8'h99;
      wbuf[1] = 8'h98;
      chk("both_ready", {31'd0, a_arready && a_awready}, 1);
      fork
         wr(8'h80, 4'd4, 2, {4'd4, 1'b0}, {4'd4, 1'b0}, 0);
         rd(8'h40, 4'd3, 4'd0, 16'hFFFF);
      join
      fill_exp(8'h80, 0, 2);
      rd(8'h80, 4'd1, 4'd4, 16'hFFFF);

      arvalid = 1'b1;
      arbus   = {8'h10, 4'd3, 4'd1};
      awvalid = 1'b1;
      awbus   = {8'h30, 4'd6};
      tick();
      arvalid = 1'b0;
      awvalid = 1'b0;
      rready  = 1'b1;
      wvalid  = 1'b1;
      wdata   = 8'hEE;
      chk("mid_rbus_beat1", a_rbus, {8'hA1, 1'b0});
      chk("mid_wready", a_wready, 1);
      tick();
      rready = 1'b0;
      wvalid = 1'b0;
      chk("mid_rbus_beat2", a_rbus, {8'hB2, 1'b0});
      rst = 1'b1;
      #1;
      chk("mid_arready", a_arready, 1);
      chk("mid_awready", a_awready, 1);
      chk("mid_rvalid", a_rvalid, 0);
      chk("mid_rlast", a_rlast, 0);
      chk("mid_rbus", a_rbus, 0);
      chk("mid_wready_rst", a_wready, 0);
      chk("mid_bvalid", a_bvalid, 0);
      chk("mid_bresp", a_bresp, 0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("post_rst_bvalid", a_bvalid, 0);
         chk("post_rst_rvalid", a_rvalid, 0);
         tick();
      end
      wbuf[0] = 8'h5C;
      wr(8'h30, 4'd6, 1, {4'd6, 1'b0}, {4'd6, 1'b0}, 0);
      fill_exp(8'h30, 0, 1);
      rd(8'h30, 4'd0, 4'd1, 16'hFFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
